// File: rtl/ysyx_24100006_axi_arbiter.sv
// Purpose: arbitrates IFU reads and LSU reads/writes onto one downstream AXI master port.
// Latency: a request seen in IDLE is granted on the next edge; the channels are then passed through combinationally.
// Backpressure: the owner sees downstream ready/valid directly; non-owners see 0 until the arbiter returns to IDLE.
module ysyx_24100006_axi_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int SIZE_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  // IFU read
  input  logic                    ifu_arvalid_i,
  input  logic [ADDR_WIDTH-1:0]   ifu_araddr_i,
  input  logic [LEN_WIDTH-1:0]    ifu_arlen_i,
  input  logic [SIZE_WIDTH-1:0]   ifu_arsize_i,
  output logic                    ifu_arready_o,
  input  logic                    ifu_rready_i,
  output logic                    ifu_rvalid_o,
  output logic [1:0]              ifu_rresp_o,
  output logic [DATA_WIDTH-1:0]   ifu_rdata_o,
  output logic                    ifu_rlast_o,
  // LSU read
  input  logic                    lsu_arvalid_i,
  input  logic [ADDR_WIDTH-1:0]   lsu_araddr_i,
  input  logic [LEN_WIDTH-1:0]    lsu_arlen_i,
  input  logic [SIZE_WIDTH-1:0]   lsu_arsize_i,
  output logic                    lsu_arready_o,
  input  logic                    lsu_rready_i,
  output logic                    lsu_rvalid_o,
  output logic [1:0]              lsu_rresp_o,
  output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
  output logic                    lsu_rlast_o,
  // LSU write
  input  logic                    lsu_awvalid_i,
  input  logic [ADDR_WIDTH-1:0]   lsu_awaddr_i,
  input  logic [LEN_WIDTH-1:0]    lsu_awlen_i,
  input  logic [SIZE_WIDTH-1:0]   lsu_awsize_i,
  output logic                    lsu_awready_o,
  input  logic                    lsu_wvalid_i,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] lsu_wstrb_i,
  input  logic                    lsu_wlast_i,
  output logic                    lsu_wready_o,
  input  logic                    lsu_bready_i,
  output logic                    lsu_bvalid_o,
  output logic [1:0]              lsu_bresp_o,
  // downstream (bridge CPU side)
  output logic                    m_arvalid_o,
  output logic [ADDR_WIDTH-1:0]   m_araddr_o,
  output logic [LEN_WIDTH-1:0]    m_arlen_o,
  output logic [SIZE_WIDTH-1:0]   m_arsize_o,
  output logic [1:0]              m_arburst_o,
  output logic [3:0]              m_arid_o,
  input  logic                    m_arready_i,
  output logic                    m_rready_o,
  input  logic                    m_rvalid_i,
  input  logic [1:0]              m_rresp_i,
  input  logic [DATA_WIDTH-1:0]   m_rdata_i,
  input  logic                    m_rlast_i,
  output logic                    m_awvalid_o,
  output logic [ADDR_WIDTH-1:0]   m_awaddr_o,
  output logic [LEN_WIDTH-1:0]    m_awlen_o,
  output logic [SIZE_WIDTH-1:0]   m_awsize_o,
  output logic [1:0]              m_awburst_o,
  output logic [3:0]              m_awid_o,
  input  logic                    m_awready_i,
  output logic                    m_wvalid_o,
  output logic [DATA_WIDTH-1:0]   m_wdata_o,
  output logic [DATA_WIDTH/8-1:0] m_wstrb_o,
  output logic                    m_wlast_o,
  input  logic                    m_wready_i,
  output logic                    m_bready_o,
  input  logic                    m_bvalid_i,
  input  logic [1:0]              m_bresp_i,
  output logic [1:0]              grant_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    IFU_RD = 2'b01,
    LSU_RD = 2'b10,
    LSU_WR = 2'b11
  } state_t;

  state_t state, state_nxt;
  logic   last_grant, last_grant_nxt;  // 1 = LSU owned the bus last, 0 = IFU
  logic   ar_done, aw_done, w_done;
  logic   lsu_req;
  logic   ar_hs, aw_hs, w_hs;

  assign lsu_req     = lsu_arvalid_i | lsu_awvalid_i;
  assign ar_hs       = m_arvalid_o & m_arready_i;
  assign aw_hs       = m_awvalid_o & m_awready_i;
  assign w_hs        = m_wvalid_o & m_wready_i & m_wlast_o;
  assign grant_o     = state;
  assign m_arburst_o = 2'b01;
  assign m_awburst_o = 2'b01;
  assign m_arid_o    = 4'd0;
  assign m_awid_o    = 4'd0;

  // State, fairness flop and per-channel done flags; flags clear whenever we head back to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      ar_done    <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      if (state_nxt == IDLE) begin
        ar_done <= 1'b0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (ar_hs) ar_done <= 1'b1;
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
    end
  end

  // Arbitration in IDLE (write beats read within LSU, last_grant breaks IFU/LSU ties) and burst-end detection.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (ifu_arvalid_i && lsu_req && last_grant) state_nxt = IFU_RD;
        else if (lsu_req)                           state_nxt = lsu_awvalid_i ? LSU_WR : LSU_RD;
        else if (ifu_arvalid_i)                     state_nxt = IFU_RD;
        if (state_nxt != IDLE) last_grant_nxt = (state_nxt != IFU_RD);
      end
      IFU_RD, LSU_RD: if (m_rvalid_i && m_rready_o && m_rlast_i) state_nxt = IDLE;
      LSU_WR:         if (m_bvalid_i && m_bready_o && aw_done && w_done) state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  // Channel routing: only the owner is connected; everything else, and everything in IDLE, is held at 0.
  always_comb begin
    ifu_arready_o = 1'b0; ifu_rvalid_o = 1'b0; ifu_rresp_o = '0; ifu_rdata_o = '0; ifu_rlast_o = 1'b0;
    lsu_arready_o = 1'b0; lsu_rvalid_o = 1'b0; lsu_rresp_o = '0; lsu_rdata_o = '0; lsu_rlast_o = 1'b0;
    lsu_awready_o = 1'b0; lsu_wready_o = 1'b0; lsu_bvalid_o = 1'b0; lsu_bresp_o = '0;
    m_arvalid_o = 1'b0; m_araddr_o = '0; m_arlen_o = '0; m_arsize_o = '0; m_rready_o = 1'b0;
    m_awvalid_o = 1'b0; m_awaddr_o = '0; m_awlen_o = '0; m_awsize_o = '0;
    m_wvalid_o  = 1'b0; m_wdata_o  = '0; m_wstrb_o = '0; m_wlast_o  = 1'b0; m_bready_o = 1'b0;
    case (state)
      IFU_RD: begin
        m_arvalid_o   = ifu_arvalid_i & ~ar_done;
        m_araddr_o    = ifu_araddr_i;
        m_arlen_o     = ifu_arlen_i;
        m_arsize_o    = ifu_arsize_i;
        ifu_arready_o = m_arready_i;
        m_rready_o    = ifu_rready_i;
        ifu_rvalid_o  = m_rvalid_i;
        ifu_rresp_o   = m_rresp_i;
        ifu_rdata_o   = m_rdata_i;
        ifu_rlast_o   = m_rlast_i;
      end
      LSU_RD: begin
        m_arvalid_o   = lsu_arvalid_i & ~ar_done;
        m_araddr_o    = lsu_araddr_i;
        m_arlen_o     = lsu_arlen_i;
        m_arsize_o    = lsu_arsize_i;
        lsu_arready_o = m_arready_i;
        m_rready_o    = lsu_rready_i;
        lsu_rvalid_o  = m_rvalid_i;
        lsu_rresp_o   = m_rresp_i;
        lsu_rdata_o   = m_rdata_i;
        lsu_rlast_o   = m_rlast_i;
      end
      LSU_WR: begin
        m_awvalid_o   = lsu_awvalid_i & ~aw_done;
        m_awaddr_o    = lsu_awaddr_i;
        m_awlen_o     = lsu_awlen_i;
        m_awsize_o    = lsu_awsize_i;
        lsu_awready_o = m_awready_i;
        m_wvalid_o    = lsu_wvalid_i & ~w_done;
        m_wdata_o     = lsu_wdata_i;
        m_wstrb_o     = lsu_wstrb_i;
        m_wlast_o     = lsu_wlast_i;
        lsu_wready_o  = m_wready_i;
        m_bready_o    = lsu_bready_i;
        lsu_bvalid_o  = m_bvalid_i;
        lsu_bresp_o   = m_bresp_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_24100006_axi_arbiter.sv
// Purpose: self-checking bench for the IFU/LSU AXI arbiter.
// Latency: inputs change 1 time unit after the rising edge, outputs are sampled on the falling edge.
// Backpressure: downstream ready/valid are scripted per transaction; upstream rready/bready are held high.
module tb_ysyx_24100006_axi_arbiter;

  localparam logic [31:0] IFU_ADDR   = 32'h3000_0000;
  localparam logic [31:0] LSU_RADDR  = 32'h8000_0100;
  localparam logic [31:0] LSU_WADDR  = 32'h8000_0200;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_arvalid_i, ifu_arready_o, ifu_rready_i, ifu_rvalid_o, ifu_rlast_o;
  logic [31:0] ifu_araddr_i, ifu_rdata_o;
  logic [7:0]  ifu_arlen_i;
  logic [2:0]  ifu_arsize_i;
  logic [1:0]  ifu_rresp_o;
  logic        lsu_arvalid_i, lsu_arready_o, lsu_rready_i, lsu_rvalid_o, lsu_rlast_o;
  logic [31:0] lsu_araddr_i, lsu_rdata_o;
  logic [7:0]  lsu_arlen_i;
  logic [2:0]  lsu_arsize_i;
  logic [1:0]  lsu_rresp_o;
  logic        lsu_awvalid_i, lsu_awready_o, lsu_wvalid_i, lsu_wlast_i, lsu_wready_o;
  logic        lsu_bready_i, lsu_bvalid_o;
  logic [31:0] lsu_awaddr_i, lsu_wdata_i;
  logic [7:0]  lsu_awlen_i;
  logic [2:0]  lsu_awsize_i;
  logic [3:0]  lsu_wstrb_i;
  logic [1:0]  lsu_bresp_o;
  logic        m_arvalid_o, m_arready_i, m_rready_o, m_rvalid_i, m_rlast_i;
  logic [31:0] m_araddr_o, m_rdata_i;
  logic [7:0]  m_arlen_o;
  logic [2:0]  m_arsize_o;
  logic [1:0]  m_arburst_o, m_rresp_i;
  logic [3:0]  m_arid_o;
  logic        m_awvalid_o, m_awready_i, m_wvalid_o, m_wlast_o, m_wready_i, m_bready_o, m_bvalid_i;
  logic [31:0] m_awaddr_o, m_wdata_o;
  logic [7:0]  m_awlen_o;
  logic [2:0]  m_awsize_o;
  logic [1:0]  m_awburst_o, m_bresp_i;
  logic [3:0]  m_awid_o, m_wstrb_o;
  logic [1:0]  grant_o;

  ysyx_24100006_axi_arbiter dut (
    .clk(clk), .reset(reset),
    .ifu_arvalid_i(ifu_arvalid_i), .ifu_araddr_i(ifu_araddr_i), .ifu_arlen_i(ifu_arlen_i),
    .ifu_arsize_i(ifu_arsize_i), .ifu_arready_o(ifu_arready_o), .ifu_rready_i(ifu_rready_i),
    .ifu_rvalid_o(ifu_rvalid_o), .ifu_rresp_o(ifu_rresp_o), .ifu_rdata_o(ifu_rdata_o),
    .ifu_rlast_o(ifu_rlast_o),
    .lsu_arvalid_i(lsu_arvalid_i), .lsu_araddr_i(lsu_araddr_i), .lsu_arlen_i(lsu_arlen_i),
    .lsu_arsize_i(lsu_arsize_i), .lsu_arready_o(lsu_arready_o), .lsu_rready_i(lsu_rready_i),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rresp_o(lsu_rresp_o), .lsu_rdata_o(lsu_rdata_o),
    .lsu_rlast_o(lsu_rlast_o),
    .lsu_awvalid_i(lsu_awvalid_i), .lsu_awaddr_i(lsu_awaddr_i), .lsu_awlen_i(lsu_awlen_i),
    .lsu_awsize_i(lsu_awsize_i), .lsu_awready_o(lsu_awready_o), .lsu_wvalid_i(lsu_wvalid_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_wstrb_i(lsu_wstrb_i), .lsu_wlast_i(lsu_wlast_i),
    .lsu_wready_o(lsu_wready_o), .lsu_bready_i(lsu_bready_i), .lsu_bvalid_o(lsu_bvalid_o),
    .lsu_bresp_o(lsu_bresp_o),
    .m_arvalid_o(m_arvalid_o), .m_araddr_o(m_araddr_o), .m_arlen_o(m_arlen_o),
    .m_arsize_o(m_arsize_o), .m_arburst_o(m_arburst_o), .m_arid_o(m_arid_o),
    .m_arready_i(m_arready_i), .m_rready_o(m_rready_o), .m_rvalid_i(m_rvalid_i),
    .m_rresp_i(m_rresp_i), .m_rdata_i(m_rdata_i), .m_rlast_i(m_rlast_i),
    .m_awvalid_o(m_awvalid_o), .m_awaddr_o(m_awaddr_o), .m_awlen_o(m_awlen_o),
    .m_awsize_o(m_awsize_o), .m_awburst_o(m_awburst_o), .m_awid_o(m_awid_o),
    .m_awready_i(m_awready_i), .m_wvalid_o(m_wvalid_o), .m_wdata_o(m_wdata_o),
    .m_wstrb_o(m_wstrb_o), .m_wlast_o(m_wlast_o), .m_wready_i(m_wready_i),
    .m_bready_o(m_bready_o), .m_bvalid_i(m_bvalid_i), .m_bresp_i(m_bresp_i),
    .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ifu;
    logic        lar;
    logic        law;
    logic [1:0]  exp_grant;
    logic [31:0] dat;
    logic [1:0]  resp;
  } vec_t;

  // who: 1 = IFU R beat, 2 = LSU R beat, 3 = LSU B response
  typedef struct {
    logic [1:0]  who;
    logic [31:0] dat;
    logic [1:0]  resp;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic any_out;

  assign any_out = |{ifu_arready_o, ifu_rvalid_o, ifu_rresp_o, ifu_rdata_o, ifu_rlast_o,
                     lsu_arready_o, lsu_rvalid_o, lsu_rresp_o, lsu_rdata_o, lsu_rlast_o,
                     lsu_awready_o, lsu_wready_o, lsu_bvalid_o, lsu_bresp_o,
                     m_arvalid_o, m_araddr_o, m_arlen_o, m_arsize_o, m_arid_o, m_rready_o,
                     m_awvalid_o, m_awaddr_o, m_awlen_o, m_awsize_o, m_awid_o,
                     m_wvalid_o, m_wdata_o, m_wstrb_o, m_wlast_o, m_bready_o, grant_o};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [1:0] who, input logic [31:0] d, input logic [1:0] r, input logic l);
    exp_t e;
    e.who = who; e.dat = d; e.resp = r; e.last = l;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input logic [1:0] who, input logic [31:0] d, input logic [1:0] r, input logic l);
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: got who=%0d data=%0h, expected no beat (t=%0t)", who, d, $time);
    end else begin
      e = sb.pop_front();
      if (e.who !== who || e.dat !== d || e.resp !== r || e.last !== l) begin
        n_fail++;
        $display("FAIL sb_beat: got who=%0d data=%0h resp=%0d last=%0d, expected who=%0d data=%0h resp=%0d last=%0d",
                 who, d, r, l, e.who, e.dat, e.resp, e.last);
      end
    end
  endtask

  // Response monitor: every accepted upstream beat must match the scoreboard head.
  always @(negedge clk) begin
    if (ifu_rvalid_o && ifu_rready_i) sb_pop(2'd1, ifu_rdata_o, ifu_rresp_o, ifu_rlast_o);
    if (lsu_rvalid_o && lsu_rready_i) sb_pop(2'd2, lsu_rdata_o, lsu_rresp_o, lsu_rlast_o);
    if (lsu_bvalid_o && lsu_bready_i) sb_pop(2'd3, 32'd0, lsu_bresp_o, 1'b1);
  end

  // Entered just after the granting edge; finishes with the arbiter back in IDLE.
  task automatic read_txn(input logic [1:0] g, input logic [31:0] dat, input logic [1:0] resp);
    m_arready_i = 1'b1;
    @(negedge clk);
    chk("rd_grant", grant_o, g);
    chk("rd_m_arvalid", m_arvalid_o, 1);
    chk("rd_m_araddr", m_araddr_o, (g == 2'b01) ? IFU_ADDR : LSU_RADDR);
    chk("rd_arready_route", {ifu_arready_o, lsu_arready_o}, (g == 2'b01) ? 2'b10 : 2'b01);
    chk("rd_aw_nonowner", {m_awvalid_o, m_wvalid_o, m_bready_o}, 0);
    @(posedge clk); #1;
    m_arready_i = 1'b0;
    @(negedge clk);
    chk("rd_ar_masked", m_arvalid_o, 0);
    @(posedge clk); #1;
    ifu_arvalid_i = 1'b0; lsu_arvalid_i = 1'b0; lsu_awvalid_i = 1'b0;
    m_rvalid_i = 1'b1; m_rlast_i = 1'b1; m_rdata_i = dat; m_rresp_i = resp;
    push((g == 2'b01) ? 2'd1 : 2'd2, dat, resp, 1'b1);
    @(negedge clk);
    chk("rd_r_nonowner", (g == 2'b01) ? lsu_rvalid_o : ifu_rvalid_o, 0);
    @(posedge clk); #1;
    m_rvalid_i = 1'b0; m_rlast_i = 1'b0;
    @(negedge clk);
    chk("rd_back_idle", grant_o, 0);
  endtask

  // W completes two cycles before AW; B only closes the transaction once both are done.
  task automatic write_txn(input logic [31:0] dat, input logic [1:0] resp);
    lsu_wvalid_i = 1'b1; lsu_wlast_i = 1'b1; lsu_wdata_i = dat; m_wready_i = 1'b1;
    @(negedge clk);
    chk("wr_grant", grant_o, 2'b11);
    chk("wr_m_valids", {m_awvalid_o, m_wvalid_o, m_wlast_o, lsu_wready_o}, 4'b1111);
    chk("wr_m_awaddr_wdata", {m_awaddr_o, m_wdata_o}, {LSU_WADDR, dat});
    chk("wr_ar_nonowner", {m_arvalid_o, m_rready_o, ifu_arready_o, lsu_arready_o}, 0);
    @(posedge clk); #1;
    m_wready_i = 1'b0;
    @(negedge clk);
    chk("wr_w_masked", {m_wvalid_o, m_awvalid_o}, 2'b01);
    @(posedge clk); #1;
    m_awready_i = 1'b1;
    @(negedge clk);
    chk("wr_aw_late", {lsu_awready_o, m_awvalid_o}, 2'b11);
    @(posedge clk); #1;
    m_awready_i = 1'b0;
    @(negedge clk);
    chk("wr_aw_masked", m_awvalid_o, 0);
    chk("wr_hold_state", grant_o, 2'b11);
    @(posedge clk); #1;
    ifu_arvalid_i = 1'b0; lsu_arvalid_i = 1'b0; lsu_awvalid_i = 1'b0;
    lsu_wvalid_i = 1'b0; lsu_wlast_i = 1'b0;
    m_bvalid_i = 1'b1; m_bresp_i = resp;
    push(2'd3, 32'd0, resp, 1'b1);
    @(negedge clk);
    chk("wr_b_wait", grant_o, 2'b11);
    @(posedge clk); #1;
    m_bvalid_i = 1'b0;
    @(negedge clk);
    chk("wr_back_idle", grant_o, 0);
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    ifu_arvalid_i = v.ifu; lsu_arvalid_i = v.lar; lsu_awvalid_i = v.law;
    @(negedge clk);
    chk("idle_grant", grant_o, 0);
    chk("idle_m_quiet", {m_arvalid_o, m_awvalid_o, m_wvalid_o, m_rready_o, m_bready_o}, 0);
    @(posedge clk); #1;
    case (v.exp_grant)
      2'b01, 2'b10: read_txn(v.exp_grant, v.dat, v.resp);
      2'b11:        write_txn(v.dat, v.resp);
      default: begin
        @(negedge clk);
        chk("noreq_grant", grant_o, 0);
      end
    endcase
  endtask

  function automatic vec_t mk(input logic i, input logic ar, input logic aw, input logic [1:0] g,
                              input logic [31:0] d, input logic [1:0] r);
    vec_t v;
    v.ifu = i; v.lar = ar; v.law = aw; v.exp_grant = g; v.dat = d; v.resp = r;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish within 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    // Expected grants follow from last_grant starting at IFU after reset.
    tbl[0] = mk(1'b1, 1'b0, 1'b0, 2'b01, 32'h1111_0000, 2'b00);  // IFU alone
    tbl[1] = mk(1'b1, 1'b1, 1'b0, 2'b10, 32'h2222_0001, 2'b10);  // last=IFU -> LSU wins, SLVERR forwarded
    tbl[2] = mk(1'b1, 1'b1, 1'b0, 2'b01, 32'h3333_0002, 2'b00);  // last=LSU -> IFU wins
    tbl[3] = mk(1'b0, 1'b1, 1'b1, 2'b11, 32'h4444_0003, 2'b10);  // write beats read
    tbl[4] = mk(1'b1, 1'b1, 1'b1, 2'b01, 32'h5555_0004, 2'b00);  // last=LSU -> IFU wins
    tbl[5] = mk(1'b1, 1'b0, 1'b1, 2'b11, 32'h6666_0005, 2'b00);  // last=IFU -> LSU write
    tbl[6] = mk(1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         2'b00);  // no request stays idle
    tbl[7] = mk(1'b0, 1'b1, 1'b0, 2'b10, 32'h7777_0007, 2'b11);  // DECERR forwarded

    reset = 1'b0;
    ifu_arvalid_i = 0; ifu_araddr_i = IFU_ADDR; ifu_arlen_i = 0; ifu_arsize_i = 3'd2; ifu_rready_i = 1;
    lsu_arvalid_i = 0; lsu_araddr_i = LSU_RADDR; lsu_arlen_i = 0; lsu_arsize_i = 3'd2; lsu_rready_i = 1;
    lsu_awvalid_i = 0; lsu_awaddr_i = LSU_WADDR; lsu_awlen_i = 0; lsu_awsize_i = 3'd2;
    lsu_wvalid_i = 0; lsu_wdata_i = 0; lsu_wstrb_i = 4'hF; lsu_wlast_i = 0; lsu_bready_i = 1;
    m_arready_i = 0; m_rvalid_i = 0; m_rresp_i = 0; m_rdata_i = 0; m_rlast_i = 0;
    m_awready_i = 0; m_wready_i = 0; m_bvalid_i = 0; m_bresp_i = 0;
    #2;
    chk("reset_outputs", any_out, 0);
    chk("reset_burst_incr", {m_arburst_o, m_awburst_o}, 4'b0101);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // IFU burst of 4 with an LSU request arriving mid-way: no regrant until rlast.
    @(posedge clk); #1;
    ifu_arvalid_i = 1'b1; ifu_arlen_i = 8'd3;
    @(posedge clk); #1;
    lsu_arvalid_i = 1'b1; m_arready_i = 1'b1;
    @(negedge clk);
    chk("burst_grant_ifu", grant_o, 2'b01);
    chk("burst_arlen", m_arlen_o, 8'd3);
    @(posedge clk); #1;
    m_arready_i = 1'b0; ifu_arvalid_i = 1'b0; ifu_arlen_i = 8'd0;
    for (int b = 0; b < 4; b++) begin
      m_rvalid_i = 1'b1; m_rlast_i = (b == 3); m_rdata_i = 32'hB000_0000 + b; m_rresp_i = 2'b00;
      push(2'd1, 32'hB000_0000 + b, 2'b00, (b == 3));
      @(negedge clk);
      chk("burst_no_regrant", grant_o, 2'b01);
      @(posedge clk); #1;
    end
    m_rvalid_i = 1'b0; m_rlast_i = 1'b0;
    @(negedge clk);
    chk("burst_idle_after_last", grant_o, 0);
    @(posedge clk); #1;
    read_txn(2'b10, 32'hC0DE_0010, 2'b00);

    // Stray write response while idle must not be accepted or forwarded.
    @(posedge clk); #1;
    m_bvalid_i = 1'b1; m_bresp_i = 2'b11;
    @(negedge clk);
    chk("stray_b", {m_bready_o, lsu_bvalid_o, grant_o}, 0);
    @(posedge clk); #1;
    m_bvalid_i = 1'b0; m_bresp_i = 2'b00;

    // Reset during an LSU burst: outputs drop at once, then normal arbitration resumes.
    @(posedge clk); #1;
    lsu_arvalid_i = 1'b1; lsu_arlen_i = 8'd3;
    @(posedge clk); #1;
    m_arready_i = 1'b1;
    @(posedge clk); #1;
    m_arready_i = 1'b0; lsu_arvalid_i = 1'b0;
    m_rvalid_i = 1'b1; m_rlast_i = 1'b0; m_rdata_i = 32'hDEAD_0001;
    push(2'd2, 32'hDEAD_0001, 2'b00, 1'b0);
    @(negedge clk);
    chk("midburst_grant", grant_o, 2'b10);
    @(posedge clk); #1;
    m_rdata_i = 32'hDEAD_0002;
    reset = 1'b0;
    #1;
    chk("async_reset_grant", grant_o, 0);
    chk("async_reset_outputs", any_out, 0);
    @(posedge clk); #1;
    m_rvalid_i = 1'b0; m_rdata_i = 0; lsu_arlen_i = 8'd0;
    reset = 1'b1;

    // First conflict after reset goes to LSU, the next to IFU.
    run_vec(mk(1'b1, 1'b1, 1'b0, 2'b10, 32'hA5A5_0001, 2'b00));
    run_vec(mk(1'b1, 1'b1, 1'b0, 2'b01, 32'h5A5A_0002, 2'b00));

    @(posedge clk);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_24100006_axi_arbiter.md
YSYX_24100006_AXI_ARBITER -- requirements
Module: ysyx_24100006_axi_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning address width of all channels.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data width; strobe width is DATA_WIDTH/8.
REQ-003 SHALL have parameter LEN_WIDTH, default 8, meaning burst length field width.
REQ-004 SHALL have parameter SIZE_WIDTH, default 3, meaning burst size field width.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning the reset: asynchronous and active-low (0 = reset asserted).
REQ-007 SHALL have IFU read-address ports: ifu_arvalid_i, ifu_araddr_i, ifu_arlen_i and ifu_arsize_i as inputs; ifu_arready_o as output.
REQ-008 SHALL have IFU read-data ports: ifu_rready_i as input; ifu_rvalid_o, ifu_rresp_o (2), ifu_rdata_o and ifu_rlast_o as outputs.
REQ-009 SHALL have LSU read-address ports: lsu_arvalid_i, lsu_araddr_i, lsu_arlen_i and lsu_arsize_i as inputs; lsu_arready_o as output.
REQ-010 SHALL have LSU read-data ports: lsu_rready_i as input; lsu_rvalid_o, lsu_rresp_o (2), lsu_rdata_o and lsu_rlast_o as outputs.
REQ-011 SHALL have LSU write-address ports: lsu_awvalid_i, lsu_awaddr_i, lsu_awlen_i and lsu_awsize_i as inputs; lsu_awready_o as output.
REQ-012 SHALL have LSU write-data ports: lsu_wvalid_i, lsu_wdata_i, lsu_wstrb_i and lsu_wlast_i as inputs; lsu_wready_o as output.
REQ-013 SHALL have LSU write-response ports: lsu_bready_i as input; lsu_bvalid_o and lsu_bresp_o (2) as outputs.
REQ-014 SHALL have downstream ports m_ar*, m_r*, m_aw*, m_w* and m_b*, mirroring REQ-009..013 with directions reversed, which connect to the AXI bridge's CPU side.
REQ-015 SHALL have port grant_o, output, 2, meaning current state encoding (debug).

Function
REQ-016 SHALL implement FSM states IDLE=00, IFU_RD=01, LSU_RD=10 and LSU_WR=11, with grant_o equal to the state.
REQ-017 SHALL sample requests only in IDLE; a request is ifu_arvalid_i, lsu_arvalid_i or lsu_awvalid_i.
REQ-018 SHALL, for a single request in IDLE, move to the matching state on the next edge, so the first downstream valid appears 1 cycle after the request.
REQ-019 SHALL give LSU_WR priority over LSU_RD when lsu_awvalid_i and lsu_arvalid_i are both high.
REQ-020 SHALL resolve an IFU-vs-LSU conflict with a last_grant flop: if last_grant=LSU, IFU wins, otherwise LSU wins.
REQ-021 SHALL update last_grant on every IDLE exit.
REQ-022 SHALL, in the granted state, pass the owner's channel signals combinationally to m_* and pass m_* ready/valid/data back to the owner only.
REQ-023 SHALL hold every non-owner ready/valid output at 0 and every non-owner data output at 0.
REQ-024 SHALL, in IDLE, drive all m_*valid, m_rready and m_bready to 0 so that stray responses are never accepted.
REQ-025 SHALL set an ar_done flag on the m_arvalid&m_arready handshake and mask m_arvalid to 0 while ar_done=1.
REQ-026 SHALL likewise use aw_done to mask m_awvalid after its handshake, and w_done to mask m_wvalid after the m_wvalid&m_wready&m_wlast handshake.
REQ-027 SHALL leave a read state for IDLE on m_rvalid&m_rready&m_rlast.
REQ-028 SHALL leave LSU_WR for IDLE on m_bvalid&m_bready, and only once aw_done and w_done are both set.
REQ-029 SHALL clear all done flags when entering IDLE.
REQ-030 SHALL allow the AW and W handshakes in either order or in the same cycle.
REQ-031 SHALL forward rresp/bresp unmodified, error responses included, without changing FSM behaviour.
REQ-032 SHALL keep the current state while a burst length >0 is in progress (beats with rlast=0); it SHALL not re-arbitrate mid-burst.
REQ-033 SHALL drive m_arburst/m_awburst as INCR (2'b01) and all IDs as 0.

Reset
REQ-034 SHALL, on reset low, asynchronously set state to IDLE, last_grant to IFU, all done flags to 0, and every valid/ready output to 0.
REQ-035 SHALL, on reset asserted mid-transaction, abandon the transaction immediately; after release the arbiter SHALL resume from IDLE.

Verification
REQ-036 SHALL verify: IFU alone with arlen=0 and addr 0x3000_0000 -> grant_o=01 next cycle, one beat to IFU, return to IDLE after rlast.
REQ-037 SHALL verify: IFU and LSU read requested in the same IDLE cycle after reset -> LSU first (grant_o=10), then IFU (01).
REQ-038 SHALL verify: LSU write where W handshakes 2 cycles before AW -> IDLE is reached only after bvalid&bready, with m_awvalid never re-asserted.
REQ-039 SHALL verify: IFU burst arlen=3 while LSU requests -> 4 beats to IFU with no grant change, then LSU granted.
REQ-040 SHALL verify: stray m_bvalid=1 in IDLE -> m_bready=0 and lsu_bvalid_o=0.
REQ-041 SHALL verify: reset asserted in LSU_RD mid-burst -> all outputs 0 in the same cycle and grant_o=00.
